// File: rtl/fp32_sqrt_unpack.sv
// Input stage of the binary32 square-root pipeline: classifies the operand, builds the
// 48-bit radicand and delays exponent/sign/class alongside the root engine.
module fp32_sqrt_unpack #(
    parameter int unsigned SQRT_LAT = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        vldin,
    input  logic [31:0] ain,
    output logic        rad_vld,
    output logic [47:0] rad,
    output logic        sb_vld,
    output logic [7:0]  sb_exp,
    output logic        sb_sign,
    output logic [1:0]  sb_class
);

    logic               sgn;
    logic [7:0]         bexp;
    logic [22:0]        frac;
    logic [23:0]        sub_mant;
    logic [4:0]         lz;
    logic [23:0]        mant;
    logic signed [9:0]  exp_unb;
    logic signed [9:0]  exp_half;
    logic [1:0]         cls;
    logic               sign_c;
    logic [7:0]         exp_c;
    logic [47:0]        rad_c;

    always_comb begin
        sgn      = ain[31];
        bexp     = ain[30:23];
        frac     = ain[22:0];
        sub_mant = {1'b0, frac};
        cls      = 2'd0;
        sign_c   = 1'b0;
        lz       = 5'd0;

        if (bexp == 8'hff && frac != 23'd0) begin
            cls = 2'd3;
        end else if (bexp == 8'h00 && frac == 23'd0) begin
            cls    = 2'd1;
            sign_c = sgn;
        end else if (sgn) begin
            cls = 2'd3;
        end else if (bexp == 8'hff) begin
            cls = 2'd2;
        end

        // Highest set bit wins since later iterations overwrite earlier ones.
        for (int i = 0; i < 24; i++) begin
            if (sub_mant[i]) lz = 5'(23 - i);
        end

        if (bexp != 8'h00) begin
            mant    = {1'b1, frac};
            exp_unb = $signed({2'b00, bexp}) - 10'sd127;
        end else begin
            mant    = sub_mant << lz;
            exp_unb = -10'sd126 - $signed({5'b00000, lz});
        end

        exp_half = (exp_unb >>> 1) + 10'sd127;
        exp_c    = exp_half[7:0];
        // Odd exponents take the extra shift so the root's exponent halves exactly.
        rad_c    = exp_unb[0] ? {mant, 24'd0} : {1'b0, mant, 23'd0};

        if (cls != 2'd0) begin
            rad_c = 48'd0;
            exp_c = 8'd0;
        end
    end

    logic        rad_vld_q;
    logic [47:0] rad_q;
    // Sideband stages: {vld, exp, sign, class}; stage 0 is the input register.
    logic [11:0] sb_q [SQRT_LAT+1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rad_vld_q <= 1'b0;
            rad_q     <= 48'd0;
            for (int i = 0; i <= int'(SQRT_LAT); i++) sb_q[i] <= 12'd0;
        end else if (en) begin
            rad_vld_q <= vldin;
            rad_q     <= rad_c;
            sb_q[0]   <= {vldin, exp_c, sign_c, cls};
            for (int i = 1; i <= int'(SQRT_LAT); i++) sb_q[i] <= sb_q[i-1];
        end
    end

    assign rad_vld  = rad_vld_q;
    assign rad      = rad_q;
    assign sb_vld   = sb_q[SQRT_LAT][11];
    assign sb_exp   = sb_q[SQRT_LAT][10:3];
    assign sb_sign  = sb_q[SQRT_LAT][2];
    assign sb_class = sb_q[SQRT_LAT][1:0];

endmodule

// File: tb/tb_fp32_sqrt_unpack.sv
// Randomised bench for fp32_sqrt_unpack against an arithmetic reference model and a
// queue that stands in for the enabled-cycle latency.
module tb_fp32_sqrt_unpack;

    localparam int LAT = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        vldin;
    logic [31:0] ain;
    logic        rad_vld;
    logic [47:0] rad;
    logic        sb_vld;
    logic [7:0]  sb_exp;
    logic        sb_sign;
    logic [1:0]  sb_class;

    fp32_sqrt_unpack #(.SQRT_LAT(LAT)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .vldin    (vldin),
        .ain      (ain),
        .rad_vld  (rad_vld),
        .rad      (rad),
        .sb_vld   (sb_vld),
        .sb_exp   (sb_exp),
        .sb_sign  (sb_sign),
        .sb_class (sb_class)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        vld;
        logic [7:0]  exp;
        logic        sign;
        logic [1:0]  cls;
        logic [47:0] rad;
    } rec_t;

    rec_t pipe[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
        n_tests++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, expv, $time);
        end
    endtask

    // Reference: value = m * 2^e with 1 <= m/2^23 < 2; radicand scaled so e becomes even.
    function automatic rec_t ref_model(input logic [31:0] a, input logic v);
        rec_t        r;
        int          bexp;
        int          e;
        longint      m;
        longint      frac;
        logic        s;
        r     = '0;
        r.vld = v;
        s     = a[31];
        bexp  = int'(a[30:23]);
        frac  = longint'(a[22:0]);
        if (bexp == 255 && frac != 0)    r.cls = 2'd3;
        else if (bexp == 0 && frac == 0) begin r.cls = 2'd1; r.sign = s; end
        else if (s)                      r.cls = 2'd3;
        else if (bexp == 255)            r.cls = 2'd2;
        else                             r.cls = 2'd0;
        if (r.cls == 2'd0) begin
            if (bexp != 0) begin
                m = (64'd1 << 23) + frac;
                e = bexp - 127;
            end else begin
                m = frac;
                e = -126;
                while (m < (64'd1 << 23)) begin
                    m = m * 2;
                    e = e - 1;
                end
            end
            if (e % 2 != 0) begin
                r.rad = 48'(m * (64'd1 << 24));
                r.exp = 8'((e - 1) / 2 + 127);
            end else begin
                r.rad = 48'(m * (64'd1 << 23));
                r.exp = 8'(e / 2 + 127);
            end
        end
        return r;
    endfunction

    task automatic check_outputs(input string tag);
        rec_t er;
        rec_t es;
        er = (pipe.size() > 0) ? pipe[pipe.size()-1] : '0;
        es = (pipe.size() == LAT + 1) ? pipe[0] : '0;
        check({tag, ".rad_vld"}, 64'(rad_vld), 64'(er.vld));
        check({tag, ".rad"}, 64'(rad), 64'(er.rad));
        check({tag, ".sb_vld"}, 64'(sb_vld), 64'(es.vld));
        if (es.vld || sb_vld) begin
            check({tag, ".sb_exp"}, 64'(sb_exp), 64'(es.exp));
            check({tag, ".sb_sign"}, 64'(sb_sign), 64'(es.sign));
            check({tag, ".sb_class"}, 64'(sb_class), 64'(es.cls));
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".rad_vld"}, 64'(rad_vld), 64'd0);
        check({tag, ".rad"}, 64'(rad), 64'd0);
        check({tag, ".sb_vld"}, 64'(sb_vld), 64'd0);
        check({tag, ".sb_exp"}, 64'(sb_exp), 64'd0);
        check({tag, ".sb_sign"}, 64'(sb_sign), 64'd0);
        check({tag, ".sb_class"}, 64'(sb_class), 64'd0);
    endtask

    // Called at a negedge; drives, clocks, updates the model and checks at the next negedge.
    task automatic cycle(input string tag, input logic e, input logic v, input logic [31:0] a);
        en    = e;
        vldin = v;
        ain   = a;
        @(posedge clk);
        if (e) begin
            pipe.push_back(ref_model(a, v));
            if (pipe.size() > LAT + 1) void'(pipe.pop_front());
        end
        @(negedge clk);
        check_outputs(tag);
    endtask

    function automatic logic [31:0] rand_operand();
        logic [31:0] specials [6] = '{32'h80000000, 32'h00000000, 32'h7F800000,
                                      32'hFF800000, 32'hBF800000, 32'h7FC00000};
        case ($urandom_range(0, 3))
            0:       return $urandom;
            1:       return {9'd0, 23'($urandom_range(1, 23'h7fffff))};
            2:       return {1'b0, 8'($urandom_range(1, 254)), 23'($urandom)};
            default: return specials[$urandom_range(0, 5)];
        endcase
    endfunction

    initial begin
        logic [31:0] dir_ops [12] = '{32'h40800000, 32'h40000000, 32'h3F800000,
                                      32'h00000001, 32'h00400000, 32'h80000000,
                                      32'h00000000, 32'h7F800000, 32'hFF800000,
                                      32'hBF800000, 32'h7FC00000, 32'h3E800000};
        rst   = 1'b1;
        en    = 1'b0;
        vldin = 1'b0;
        ain   = 32'd0;
        #1;
        check_zero("reset_async");
        @(negedge clk);
        @(negedge clk);
        check_zero("reset_hold");
        rst = 1'b0;

        // Directed operands back to back, then flush through the sideband.
        foreach (dir_ops[i]) cycle("directed", 1'b1, 1'b1, dir_ops[i]);
        for (int i = 0; i < LAT + 2; i++) cycle("flush", 1'b1, 1'b0, 32'd0);

        // Stream with random stalls and bubbles.
        for (int i = 0; i < 300; i++)
            cycle("stall", 1'(($urandom_range(0, 3) != 0)), 1'(($urandom_range(0, 4) != 0)),
                  rand_operand());

        // Reset with operands in flight.
        for (int i = 0; i < 3; i++) cycle("pre_rst", 1'b1, 1'b1, rand_operand());
        #2;
        rst = 1'b1;
        #1;
        check_zero("mid_reset");
        pipe.delete();
        @(negedge clk);
        check_zero("mid_reset_hold");
        rst = 1'b0;
        cycle("post_rst", 1'b1, 1'b1, 32'h40800000);
        for (int i = 0; i < LAT + 3; i++) cycle("post_rst", 1'b1, 1'b0, 32'd0);

        for (int i = 0; i < 300; i++)
            cycle("random", 1'(($urandom_range(0, 5) != 0)), 1'($urandom_range(0, 1)),
                  rand_operand());

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fp32_sqrt_unpack.md
# fp32_sqrt_unpack

- Input stage of the single-precision square-root pipeline.
- Takes an IEEE-754 binary32 operand and classifies it (normal, zero, inf, NaN/negative).
- Normalises subnormals and produces the 48-bit unsigned radicand for the downstream `sqrt_u48_6` root engine.
- Carries the result exponent, sign and class through an enable-gated sideband delay line, so they emerge in the same cycle as the engine's 24-bit root for final packing.

## Interface
Parameters:
- SQRT_LAT, 5, register latency of the downstream root engine in enabled cycles; sideband delay depth.

Ports:
- clk  in  1  clock; all flops rise-edge.
- rst  in  1  reset; one clock, asynchronous, active-high.
- en  in  1  pipeline advance; shared with the root engine; when 0 every flop in this block holds.
- vldin  in  1  operand valid.
- ain  in  32  binary32 operand.
- rad_vld  out  1  radicand valid; drives engine `vldin`.
- rad  out  48  unsigned radicand; drives engine `ain`.
- sb_vld  out  1  sideband valid, aligned with engine `vldout`.
- sb_exp  out  8  biased result exponent.
- sb_sign  out  1  result sign; meaningful only for class 1.
- sb_class  out  2  0 = normal, 1 = zero, 2 = +inf, 3 = NaN.

## Operation
- Decode: S = ain[31], E = ain[30:23], F = ain[22:0].
- Classification, first match wins:
  - E = 255, F != 0 -> class 3.
  - E = 0, F = 0 -> class 1, sb_sign = S.
  - S = 1 -> class 3.
  - E = 255 -> class 2.
  - Otherwise -> class 0.
- Normal operand (E != 0): m = {1, F}, 24 bits; unbiased exponent e = E - 127.
- Subnormal operand (E = 0, F != 0):
  - k = leading-zero count of {0, F} over 24 bits, range 1..23.
  - m = {0, F} << k, so m[23] = 1.
  - e = -126 - k.
- e is signed 10-bit; range -149..127.
- Radicand: e even -> rad = m << 23; e odd -> rad = m << 24. Result: rad[47:46] != 0.
- sb_exp = (e >>> 1) + 127, arithmetic shift, i.e. floor(e/2). Range 52..190; no overflow or underflow.
- For class != 0: rad = 0, sb_exp = 0. sb_sign = 0 except for class 1.
- Sideband {vld, exp, sign, class} enters a SQRT_LAT-deep shift register after the input register. Each stage advances only when en = 1.
- No backpressure beyond `en`; every accepted vldin produces exactly one rad_vld and one sb_vld.

## Timing
- Input register: with en = 1 at edge n and vldin = 1, rad/rad_vld reflect that operand after edge n; 1 enabled cycle.
- Sideband: sb_* reflect the operand 1 + SQRT_LAT enabled cycles after capture, same edge as engine out/vldout.
- en = 0: all outputs hold their values; the cycle does not count toward latency.
- vldin = 0 with en = 1: a bubble (vld = 0) propagates; data fields still load the decode of ain. Consumers qualify on vld.
- Full throughput: one operand per enabled cycle; back-to-back operands never merge or drop.
- Reset: asynchronous assertion clears every flop immediately. rad_vld, rad, sb_vld, sb_exp, sb_sign, sb_class = 0 for the whole time rst is high.
- Reset mid-operation discards all in-flight sideband. The engine must be reset or flushed together with this block.
- First capture after reset release happens at the first rising edge with rst = 0 and en = 1.

## Test plan
- 0x40800000 (4.0) -> rad = 0x400000000000, sb_exp = 128, class 0 at +6 cycles; engine root 0x800000.
- 0x40000000 (2.0) -> rad = 0x800000000000, sb_exp = 127, class 0; 0x3F800000 (1.0) -> rad = 0x400000000000, sb_exp = 127.
- Subnormal 0x00000001 -> k = 23, e = -149, rad = 0x800000000000, sb_exp = 52. Subnormal 0x00400000 -> k = 1, e = -127, rad = 0x800000000000, sb_exp = 63.
- Specials, one per cycle, with rad = 0 for each:
  - 0x80000000 -> class 1, sb_sign = 1.
  - 0x00000000 -> class 1, sb_sign = 0.
  - 0x7F800000 -> class 2.
  - 0xFF800000 -> class 3.
  - 0xBF800000 -> class 3.
  - 0x7FC00000 -> class 3.
- Stall and bubbles: stream of 8 operands with en toggled pseudo-randomly and vldin gaps.
  - Sideband order matches input order.
  - sb_vld aligns with engine vldout every cycle.
  - Outputs hold while en = 0.
- Assert rst with 3 operands in flight -> all outputs 0 immediately, no stale sb_vld after release; the next operand emerges at its normal 1 + SQRT_LAT latency.
